// File: rtl/rtla_pkg.sv
// Shared definitions for the RedTin logic analyzer host controller.
// Holds the host opcodes, the reply/sync byte values, the controller state
// enumeration and a small opcode classification helper.
package rtla_pkg;

    localparam logic [7:0] OP_SET_LOW     = 8'h01;
    localparam logic [7:0] OP_SET_HIGH    = 8'h02;
    localparam logic [7:0] OP_SET_RISING  = 8'h03;
    localparam logic [7:0] OP_SET_FALLING = 8'h04;
    localparam logic [7:0] OP_ARM         = 8'h10;
    localparam logic [7:0] OP_STATUS      = 8'h20;
    localparam logic [7:0] OP_DUMP        = 8'h30;

    localparam logic [7:0] RSP_ACK   = 8'hA5;
    localparam logic [7:0] RSP_NAK   = 8'hEE;
    localparam logic [7:0] SYNC_FILL = 8'h55;
    localparam logic [7:0] SYNC_END  = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PAYLOAD    = 3'd1,
        ST_ARM        = 3'd2,
        ST_REPLY      = 3'd3,
        ST_DUMP_SYNC  = 3'd4,
        ST_DUMP_FETCH = 3'd5,
        ST_DUMP_DATA  = 3'd6
    } la_state_e;

    // True for the four opcodes that are followed by a mask payload.
    function automatic logic is_mask_op(input logic [7:0] op);
        is_mask_op = (op >= OP_SET_LOW) && (op <= OP_SET_FALLING);
    endfunction

endpackage

// File: rtl/la_tx_serializer.sv
// Byte serializer feeding the UART transmitter.
// On a start strobe it captures a WIDTH-bit word and sends bytes MSB first,
// bytes 0..last_idx, one strobe at a time. A strobe is only issued when the
// strobe was low and the transmitter idle in the same cycle. done pulses
// together with the strobe of the final byte.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            load word and begin sending
//   word             data word, MSB byte sent first
//   last_idx         index of the last byte to send (0 = single byte)
//   uart_txactive    transmitter busy
//   uart_txdata      byte to transmit, held until the next strobe
//   uart_txen        one-cycle transmit strobe
//   done             one-cycle pulse with the final strobe
module la_tx_serializer #(
    parameter int WIDTH  = 128,
    parameter int BIDX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  word,
    input  logic [BIDX_W-1:0] last_idx,
    input  logic              uart_txactive,
    output logic [7:0]        uart_txdata,
    output logic              uart_txen,
    output logic              done
);

    localparam logic [BIDX_W-1:0] BIDX_ONE = BIDX_W'(1);

    logic [WIDTH-1:0]  shift_r;
    logic [BIDX_W-1:0] idx_r;
    logic [BIDX_W-1:0] last_r;
    logic              active_r;
    logic [7:0]        txdata_r;
    logic              txen_r;
    logic              done_r;

    // Load, shift out and strobe bytes under the transmitter handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r  <= {WIDTH{1'b0}};
            idx_r    <= {BIDX_W{1'b0}};
            last_r   <= {BIDX_W{1'b0}};
            active_r <= 1'b0;
            txdata_r <= 8'h00;
            txen_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (start) begin
            shift_r  <= word;
            idx_r    <= {BIDX_W{1'b0}};
            last_r   <= last_idx;
            active_r <= 1'b1;
            txen_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (active_r && !txen_r && !uart_txactive) begin
            txdata_r <= shift_r[WIDTH-1 -: 8];
            shift_r  <= shift_r << 8;
            txen_r   <= 1'b1;
            if (idx_r == last_r) begin
                active_r <= 1'b0;
                done_r   <= 1'b1;
            end else begin
                idx_r  <= idx_r + BIDX_ONE;
                done_r <= 1'b0;
            end
        end else begin
            txen_r <= 1'b0;
            done_r <= 1'b0;
        end
    end

    assign uart_txdata = txdata_r;
    assign uart_txen   = txen_r;
    assign done        = done_r;

endmodule

// File: rtl/la_host_controller.sv
// Host command controller for the RedTin logic analyzer.
// Parses opcode bytes from the UART receiver, loads the four trigger masks,
// re-arms the analyzer and streams the capture buffer back with sync framing.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   uart_rxout, uart_rxrdy     received byte and its one-cycle strobe
//   uart_txdata, uart_txen     byte to transmit and its strobe
//   uart_txactive              transmitter busy
//   trigger_low/high/rising/falling   analyzer trigger masks
//   la_reset                   one-cycle analyzer re-arm pulse
//   la_done                    capture complete
//   la_read_addr, la_read_data capture buffer read port (1-cycle latency)
//   busy                       high whenever the controller is not idle
module la_host_controller #(
    parameter int WIDTH     = 128,
    parameter int ADDR_BITS = 9,
    parameter int TIMEOUT   = 2000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           uart_rxout,
    input  logic                 uart_rxrdy,
    output logic [7:0]           uart_txdata,
    output logic                 uart_txen,
    input  logic                 uart_txactive,
    output logic [WIDTH-1:0]     trigger_low,
    output logic [WIDTH-1:0]     trigger_high,
    output logic [WIDTH-1:0]     trigger_rising,
    output logic [WIDTH-1:0]     trigger_falling,
    output logic                 la_reset,
    input  logic                 la_done,
    output logic [ADDR_BITS-1:0] la_read_addr,
    input  logic [WIDTH-1:0]     la_read_data,
    output logic                 busy
);
    import rtla_pkg::*;

    localparam int BYTES  = WIDTH / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [BIDX_W-1:0]    BIDX_LAST = BIDX_W'(BYTES - 1);
    localparam logic [BIDX_W-1:0]    BIDX_ONE  = BIDX_W'(1);
    localparam logic [TMO_W-1:0]     TMO_MAX   = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0]     TMO_ONE   = TMO_W'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    la_state_e            state_r, state_nxt_s;
    logic                 issued_r;
    logic [1:0]           sel_r;
    logic [WIDTH-1:0]     shadow_r;
    logic [BIDX_W-1:0]    bidx_r;
    logic [TMO_W-1:0]     tmo_r;
    logic [7:0]           reply_r;
    logic [3:0]           sync_idx_r;
    logic [ADDR_BITS-1:0] addr_r;
    logic [WIDTH-1:0]     word_r;
    logic                 la_reset_r;
    logic                 busy_r;
    logic [WIDTH-1:0]     low_r, high_r, rising_r, falling_r;

    logic                 ser_start_s;
    logic [WIDTH-1:0]     ser_word_s;
    logic [BIDX_W-1:0]    ser_last_s;
    logic                 ser_done_s;
    logic                 fetch_mark_s;
    logic                 idle_op_s;
    logic                 pay_last_s;
    logic                 pay_tmo_s;
    logic [WIDTH-1:0]     shadow_nxt_s;
    logic [ADDR_BITS-1:0] addr_inc_s;

    assign idle_op_s    = (state_r == ST_IDLE) && uart_rxrdy;
    assign pay_last_s   = (state_r == ST_PAYLOAD) && uart_rxrdy && (bidx_r == BIDX_LAST);
    assign pay_tmo_s    = (state_r == ST_PAYLOAD) && !uart_rxrdy && (tmo_r == TMO_MAX);
    assign shadow_nxt_s = WIDTH'({shadow_r, uart_rxout});
    assign addr_inc_s   = addr_r + ADDR_ONE;

    // Next-state decode and serializer requests; each transmitting state
    // fires one start (tracked by issued_r) and then waits for done.
    always_comb begin
        state_nxt_s  = state_r;
        ser_start_s  = 1'b0;
        ser_word_s   = {WIDTH{1'b0}};
        ser_last_s   = {BIDX_W{1'b0}};
        fetch_mark_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (uart_rxrdy) begin
                    if (is_mask_op(uart_rxout)) begin
                        state_nxt_s = ST_PAYLOAD;
                    end else if (uart_rxout == OP_ARM) begin
                        state_nxt_s = ST_ARM;
                    end else if ((uart_rxout == OP_DUMP) && la_done) begin
                        state_nxt_s = ST_DUMP_SYNC;
                    end else begin
                        state_nxt_s = ST_REPLY;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (pay_last_s || pay_tmo_s) begin
                    state_nxt_s = ST_REPLY;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_ARM: begin
                state_nxt_s = ST_REPLY;
            end
            ST_REPLY: begin
                if (!issued_r) begin
                    ser_start_s = 1'b1;
                    ser_word_s[WIDTH-1 -: 8] = reply_r;
                end else if (ser_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPLY;
                end
            end
            ST_DUMP_SYNC: begin
                if (!issued_r) begin
                    ser_start_s = 1'b1;
                    ser_word_s[WIDTH-1 -: 8] = (sync_idx_r == 4'hF) ? SYNC_END : SYNC_FILL;
                end else if (ser_done_s && (sync_idx_r == 4'hF)) begin
                    state_nxt_s = ST_DUMP_FETCH;
                end else begin
                    state_nxt_s = ST_DUMP_SYNC;
                end
            end
            ST_DUMP_FETCH: begin
                // First cycle lets the buffer settle on the new address.
                if (!issued_r) begin
                    fetch_mark_s = 1'b1;
                end else begin
                    state_nxt_s = ST_DUMP_DATA;
                end
            end
            ST_DUMP_DATA: begin
                if (!issued_r) begin
                    ser_start_s = 1'b1;
                    ser_word_s  = word_r;
                    ser_last_s  = BIDX_LAST;
                end else if (ser_done_s) begin
                    if (addr_r == ADDR_LAST) begin
                        state_nxt_s = ST_IDLE;
                    end else if (addr_inc_s[3:0] == 4'h0) begin
                        state_nxt_s = ST_DUMP_SYNC;
                    end else begin
                        state_nxt_s = ST_DUMP_FETCH;
                    end
                end else begin
                    state_nxt_s = ST_DUMP_DATA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and per-state issue flag, cleared on every state change
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            issued_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            issued_r <= (state_nxt_s == state_r)
                        ? ((issued_r | ser_start_s | fetch_mark_s) & ~ser_done_s)
                        : 1'b0;
        end
    end

    // Opcode capture, payload shifting, mask loads and dump bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_r      <= 2'd0;
            shadow_r   <= {WIDTH{1'b0}};
            bidx_r     <= {BIDX_W{1'b0}};
            tmo_r      <= {TMO_W{1'b0}};
            reply_r    <= 8'h00;
            sync_idx_r <= 4'h0;
            addr_r     <= {ADDR_BITS{1'b0}};
            word_r     <= {WIDTH{1'b0}};
            la_reset_r <= 1'b0;
            busy_r     <= 1'b0;
            low_r      <= {WIDTH{1'b0}};
            high_r     <= {WIDTH{1'b0}};
            rising_r   <= {WIDTH{1'b0}};
            falling_r  <= {WIDTH{1'b0}};
        end else begin
            la_reset_r <= idle_op_s && (uart_rxout == OP_ARM);
            busy_r     <= (state_nxt_s != ST_IDLE);
            if (idle_op_s) begin
                // 0x01..0x04 map onto 0..3 through the low two bits minus one.
                sel_r      <= uart_rxout[1:0] - 2'd1;
                shadow_r   <= {WIDTH{1'b0}};
                bidx_r     <= {BIDX_W{1'b0}};
                tmo_r      <= {TMO_W{1'b0}};
                sync_idx_r <= 4'h0;
                addr_r     <= {ADDR_BITS{1'b0}};
                case (uart_rxout)
                    OP_SET_LOW, OP_SET_HIGH, OP_SET_RISING, OP_SET_FALLING, OP_ARM:
                        reply_r <= RSP_ACK;
                    OP_STATUS:
                        reply_r <= {7'b0000000, la_done};
                    default:
                        reply_r <= RSP_NAK;
                endcase
            end else if (state_r == ST_PAYLOAD) begin
                if (uart_rxrdy) begin
                    shadow_r <= shadow_nxt_s;
                    tmo_r    <= {TMO_W{1'b0}};
                    bidx_r   <= bidx_r + BIDX_ONE;
                    if (bidx_r == BIDX_LAST) begin
                        case (sel_r)
                            2'd0:    low_r     <= shadow_nxt_s;
                            2'd1:    high_r    <= shadow_nxt_s;
                            2'd2:    rising_r  <= shadow_nxt_s;
                            2'd3:    falling_r <= shadow_nxt_s;
                            default: low_r     <= low_r;
                        endcase
                    end
                end else if (tmo_r == TMO_MAX) begin
                    shadow_r <= {WIDTH{1'b0}};
                    reply_r  <= RSP_NAK;
                end else begin
                    tmo_r <= tmo_r + TMO_ONE;
                end
            end else if (state_r == ST_DUMP_SYNC) begin
                if (ser_done_s) begin
                    sync_idx_r <= sync_idx_r + 4'h1;
                end
            end else if (state_r == ST_DUMP_FETCH) begin
                if (issued_r) begin
                    word_r <= la_read_data;
                end
            end else if (state_r == ST_DUMP_DATA) begin
                if (ser_done_s) begin
                    addr_r <= addr_inc_s;
                end
            end
        end
    end

    la_tx_serializer #(
        .WIDTH  (WIDTH),
        .BIDX_W (BIDX_W)
    ) u_ser (
        .clk           (clk),
        .reset         (reset),
        .start         (ser_start_s),
        .word          (ser_word_s),
        .last_idx      (ser_last_s),
        .uart_txactive (uart_txactive),
        .uart_txdata   (uart_txdata),
        .uart_txen     (uart_txen),
        .done          (ser_done_s)
    );

    assign trigger_low     = low_r;
    assign trigger_high    = high_r;
    assign trigger_rising  = rising_r;
    assign trigger_falling = falling_r;
    assign la_reset        = la_reset_r;
    assign la_read_addr    = addr_r;
    assign busy            = busy_r;

endmodule

// File: tb/tb_la_host_controller.sv
// Directed self-checking bench for la_host_controller.
module tb_la_host_controller;

    localparam int WIDTH     = 128;
    localparam int ADDR_BITS = 9;
    localparam int TIMEOUT   = 40;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam int DUMP_LEN  = (DEPTH / 16) * 16 + DEPTH * 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           uart_rxout = 8'h00;
    logic                 uart_rxrdy = 1'b0;
    logic [7:0]           uart_txdata;
    logic                 uart_txen;
    logic                 uart_txactive = 1'b0;
    logic [WIDTH-1:0]     trigger_low, trigger_high, trigger_rising, trigger_falling;
    logic                 la_reset;
    logic                 la_done = 1'b0;
    logic [ADDR_BITS-1:0] la_read_addr;
    logic [WIDTH-1:0]     la_read_data = {WIDTH{1'b0}};
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    la_host_controller #(
        .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .uart_rxout(uart_rxout), .uart_rxrdy(uart_rxrdy),
        .uart_txdata(uart_txdata), .uart_txen(uart_txen), .uart_txactive(uart_txactive),
        .trigger_low(trigger_low), .trigger_high(trigger_high),
        .trigger_rising(trigger_rising), .trigger_falling(trigger_falling),
        .la_reset(la_reset), .la_done(la_done),
        .la_read_addr(la_read_addr), .la_read_data(la_read_data),
        .busy(busy)
    );

    // Capture buffer: word[n] = {16{n[7:0]}}, one cycle read latency
    always @(posedge clk) la_read_data <= {16{la_read_addr[7:0]}};

    // Transmit / re-arm monitor, sampled just after the falling edge
    logic [7:0]  txq[$];
    int unsigned txt[$];
    int unsigned cyc = 0;
    int unsigned lr_cyc = 0;
    int          lr_cnt = 0;
    int          proto_err = 0;
    logic        prev_txen = 1'b0;
    logic        prev_txact = 1'b0;
    always @(negedge clk) begin
        #1;
        cyc++;
        if (uart_txen) begin
            txq.push_back(uart_txdata);
            txt.push_back(cyc);
            if (prev_txen || prev_txact) proto_err++;
        end
        if (la_reset) begin
            lr_cnt++;
            lr_cyc = cyc;
        end
        prev_txen  = uart_txen;
        prev_txact = uart_txactive;
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rxout = b;
        uart_rxrdy = 1'b1;
        @(negedge clk);
        uart_rxrdy = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while ((txq.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        #2;
        n_cmp++;
        assert (txq.size() >= n) else begin
            n_err++;
            $error("FAIL %s: timed out with %0d bytes, expected %0d", tag, txq.size(), n);
        end
    endtask

    function automatic logic [7:0] txq_at(input int i);
        if (i < txq.size()) return txq[i];
        else return 8'hxx;
    endfunction

    initial begin
        int idx;
        int lr0;
        int n0;
        int n1;
        logic [7:0] exp_b;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txen", WIDTH'(uart_txen), WIDTH'(0));
        check("rst_txdata", WIDTH'(uart_txdata), WIDTH'(0));
        check("rst_masks", trigger_low | trigger_high | trigger_rising | trigger_falling, WIDTH'(0));
        check("rst_la_reset", WIDTH'(la_reset), WIDTH'(0));
        check("rst_addr", WIDTH'(la_read_addr), WIDTH'(0));
        check("rst_busy", WIDTH'(busy), WIDTH'(0));
        reset = 1'b0;

        // Load high mask with 00..0F
        txq.delete();
        send_byte(8'h02);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            if (i == 14) check("high_early", trigger_high, WIDTH'(0));
        end
        check("high_mask", trigger_high, 128'h000102030405060708090a0b0c0d0e0f);
        wait_tx(1, 200, "high_ack_wait");
        check("high_ack", WIDTH'(txq_at(0)), WIDTH'(8'hA5));
        check("low_zero", trigger_low, WIDTH'(0));
        check("rise_fall_zero", trigger_rising | trigger_falling, WIDTH'(0));

        // Load low mask with F0..FF
        txq.delete();
        send_byte(8'h01);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 + i));
        check("low_mask", trigger_low, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        wait_tx(1, 200, "low_ack_wait");
        check("low_ack", WIDTH'(txq_at(0)), WIDTH'(8'hA5));

        // Partial payload then silence: timeout abort
        txq.delete();
        send_byte(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i));
        repeat (TIMEOUT - 5) @(negedge clk);
        check("tmo_no_early_tx", WIDTH'(txq.size()), WIDTH'(0));
        check("tmo_busy_wait", WIDTH'(busy), WIDTH'(1));
        wait_tx(1, 200, "tmo_nak_wait");
        check("tmo_nak", WIDTH'(txq_at(0)), WIDTH'(8'hEE));
        repeat (5) @(negedge clk);
        check("tmo_low_kept", trigger_low, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
        check("tmo_high_kept", trigger_high, 128'h000102030405060708090a0b0c0d0e0f);
        check("tmo_busy_idle", WIDTH'(busy), WIDTH'(0));
        check("tmo_one_byte", WIDTH'(txq.size()), WIDTH'(1));

        // Arm
        txq.delete();
        txt.delete();
        lr0 = lr_cnt;
        send_byte(8'h10);
        check("arm_pulse", WIDTH'(la_reset), WIDTH'(1));
        @(negedge clk);
        check("arm_pulse_end", WIDTH'(la_reset), WIDTH'(0));
        wait_tx(1, 200, "arm_ack_wait");
        check("arm_ack", WIDTH'(txq_at(0)), WIDTH'(8'hA5));
        check("arm_pulse_count", WIDTH'(lr_cnt - lr0), WIDTH'(1));
        check("arm_ack_after_pulse", WIDTH'((txt.size() > 0) && (txt[0] > lr_cyc)), WIDTH'(1));

        // Status with la_done low and high
        txq.delete();
        la_done = 1'b0;
        send_byte(8'h20);
        wait_tx(1, 200, "stat0_wait");
        check("status_0", WIDTH'(txq_at(0)), WIDTH'(8'h00));
        txq.delete();
        la_done = 1'b1;
        send_byte(8'h20);
        wait_tx(1, 200, "stat1_wait");
        check("status_1", WIDTH'(txq_at(0)), WIDTH'(8'h01));

        // Unknown opcode, and dump without a finished capture
        txq.delete();
        send_byte(8'h7F);
        wait_tx(1, 200, "bad_op_wait");
        check("bad_op_nak", WIDTH'(txq_at(0)), WIDTH'(8'hEE));
        txq.delete();
        la_done = 1'b0;
        send_byte(8'h30);
        wait_tx(1, 200, "dump_nd_wait");
        repeat (20) @(negedge clk);
        check("dump_nd_nak", WIDTH'(txq_at(0)), WIDTH'(8'hEE));
        check("dump_nd_len", WIDTH'(txq.size()), WIDTH'(1));

        // Full dump with injected bytes, a transmitter stall and la_done drop
        txq.delete();
        lr0 = lr_cnt;
        la_done = 1'b1;
        send_byte(8'h30);
        repeat (300) @(negedge clk);
        send_byte(8'h20);
        send_byte(8'h03);
        repeat (1500) @(negedge clk);
        uart_txactive = 1'b1;
        #2 n0 = txq.size();
        repeat (100) @(negedge clk);
        #2 n1 = txq.size();
        @(negedge clk);
        uart_txactive = 1'b0;
        check("stall_no_strobe", WIDTH'(n1), WIDTH'(n0));
        la_done = 1'b0;
        wait_tx(DUMP_LEN, 60000, "dump_wait");
        repeat (50) @(negedge clk);
        check("dump_len", WIDTH'(txq.size()), WIDTH'(DUMP_LEN));
        idx = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (a[3:0] == 4'h0) begin
                for (int s = 0; s < 16; s++) begin
                    exp_b = (s == 15) ? 8'hAA : 8'h55;
                    check($sformatf("dump_sync[%0d]", idx), WIDTH'(txq_at(idx)), WIDTH'(exp_b));
                    idx++;
                end
            end
            for (int b = 0; b < 16; b++) begin
                exp_b = a[7:0];
                check($sformatf("dump_data[%0d]", idx), WIDTH'(txq_at(idx)), WIDTH'(exp_b));
                idx++;
            end
        end
        check("dump_addr_wrap", WIDTH'(la_read_addr), WIDTH'(0));
        check("dump_no_la_reset", WIDTH'(lr_cnt - lr0), WIDTH'(0));
        check("dump_busy_idle", WIDTH'(busy), WIDTH'(0));
        check("tx_handshake", WIDTH'(proto_err), WIDTH'(0));

        // Reset in the middle of a dump
        la_done = 1'b1;
        send_byte(8'h30);
        repeat (400) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_txen", WIDTH'(uart_txen), WIDTH'(0));
        check("mrst_txdata", WIDTH'(uart_txdata), WIDTH'(0));
        check("mrst_masks", trigger_low | trigger_high | trigger_rising | trigger_falling, WIDTH'(0));
        check("mrst_addr", WIDTH'(la_read_addr), WIDTH'(0));
        check("mrst_busy", WIDTH'(busy), WIDTH'(0));
        check("mrst_la_reset", WIDTH'(la_reset), WIDTH'(0));
        reset = 1'b0;
        txq.delete();
        send_byte(8'h20);
        wait_tx(1, 200, "mrst_stat_wait");
        check("mrst_status", WIDTH'(txq_at(0)), WIDTH'(8'h01));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/la_host_controller.md
# la_host_controller

Host-side command controller for the RedTin logic analyzer. Parses byte commands arriving from the UART receiver, holds the four trigger masks that drive the analyzer, arms the capture, and streams the finished capture buffer back through the UART transmitter with sync framing. It replaces ad-hoc dump glue in top-level testbenches and sits between `UART` and `RedTinLogicAnalyzer` in the main clock domain.

## Interface
- `WIDTH`, 128, sample/trigger width in bits; multiple of 8.
- `ADDR_BITS`, 9, capture buffer address width; depth = 2^ADDR_BITS.
- `TIMEOUT`, 2000000, idle cycles allowed between payload bytes before abort.

- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `uart_rxout`  in  8  received byte.
- `uart_rxrdy`  in  1  one-cycle strobe: `uart_rxout` valid.
- `uart_txdata`  out  8  byte to transmit.
- `uart_txen`  out  1  one-cycle transmit strobe.
- `uart_txactive`  in  1  transmitter busy.
- `trigger_low`, `trigger_high`, `trigger_rising`, `trigger_falling`  out  WIDTH each  analyzer trigger masks.
- `la_reset`  out  1  one-cycle analyzer re-arm pulse.
- `la_done`  in  1  capture complete.
- `la_read_addr`  out  ADDR_BITS  capture buffer read address.
- `la_read_data`  in  WIDTH  buffer word; valid 1 cycle after `la_read_addr` changes.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset: all outputs 0, all masks 0, state IDLE, shadow register cleared.
- Opcodes, accepted only in IDLE:
  - `0x01`..`0x04`: load low/high/rising/falling mask; followed by WIDTH/8 payload bytes, MSB first, shifted into a shadow register. The target mask is updated from the shadow in the cycle after the last byte, all bits at once. Reply `0xA5`.
  - `0x10`: arm; `la_reset` = 1 for exactly one cycle, then reply `0xA5`.
  - `0x20`: status; reply `{7'b0, la_done}`.
  - `0x30`: dump if `la_done`, else reply `0xEE`.
  - Any other opcode: reply `0xEE`.
- States: IDLE, PAYLOAD, ARM, REPLY, DUMP_SYNC, DUMP_FETCH, DUMP_DATA.
- PAYLOAD:
  - Byte counter runs 0..WIDTH/8-1.
  - Timeout counter resets on each `uart_rxrdy`. Reaching TIMEOUT discards the shadow, leaves the mask unchanged, and replies `0xEE`.
- Dump sequence:
  - DUMP_SYNC sends 15×`0x55` then `0xAA`.
  - DUMP_FETCH sets the address and waits 1 cycle.
  - DUMP_DATA sends the word as WIDTH/8 bytes, MSB first, from a register latched in DUMP_FETCH.
  - A sync block precedes word 0 and every word where address[3:0] = 0.
  - After address 2^ADDR_BITS-1: `la_read_addr` wraps to 0, no `la_reset` is issued, return to IDLE. Re-arming is only by explicit `0x10`.
- Bytes arriving on `uart_rxrdy` outside IDLE/PAYLOAD are dropped silently.
- Mid-operation `reset` aborts immediately. Masks return to 0; any partial transmit is abandoned.

## Timing
- Transmit handshake: assert `uart_txen` only when `uart_txen` = 0 and `uart_txactive` = 0 in the same cycle. This allows at most one strobe per two cycles.
- `uart_txdata` is held stable from the `uart_txen` cycle until the next strobe.
- Mask update latency: 1 cycle after the `uart_rxrdy` of the last payload byte.
- `la_reset` is asserted 1 cycle after the `0x10` `uart_rxrdy`. The `0xA5` strobe comes no earlier than the cycle after `la_reset`.
- Reply-to-opcode latency: at least 1 cycle after `uart_rxrdy`, gated only by the transmitter.
- `la_done` is sampled once, in the opcode cycle for `0x20`/`0x30`. A later drop does not abort a running dump.
- Counter widths:
  - Byte index: clog2(WIDTH/8) bits.
  - Sync index: 4 bits.
  - Timeout counter: clog2(TIMEOUT+1) bits, saturating.

## Structure
- Shared package `rtla_pkg`:
  - Opcode constants `OP_SET_LOW/HIGH/RISING/FALLING`, `OP_ARM`, `OP_STATUS`, `OP_DUMP`.
  - Reply constants `RSP_ACK = 0xA5`, `RSP_NAK = 0xEE`, `SYNC_FILL = 0x55`, `SYNC_END = 0xAA`.
  - The state enumeration.
- One sub-module, `la_tx_serializer`: takes a WIDTH-bit word plus a start strobe, emits MSB-first bytes under the `uart_txen`/`uart_txactive` rule, and raises a done pulse. Used by both DUMP_SYNC (constant word) and DUMP_DATA.

## Test plan
- `0x02` + 16 bytes `0x00..0x0F` → `trigger_high` = 128'h000102…0F one cycle after the 16th byte; `0xA5` transmitted; other masks remain 0.
- `0x01` + 5 bytes, then silence for TIMEOUT cycles → `trigger_low` unchanged, `0xEE` sent, `busy` = 0 afterwards.
- `0x10` → `la_reset` high for exactly 1 cycle, then `0xA5`. `0x20` with `la_done` = 0 → `0x00`; with `la_done` = 1 → `0x01`.
- `0x30` with `la_done` = 1 and buffer word[n] = {16{n[7:0]}} → 32 sync blocks × 16 bytes plus 512×16 data bytes in order; `la_read_addr` ends at 0; no `la_reset`.
- `0x30` with `la_done` = 0 → single `0xEE`. Opcode `0x7F` → `0xEE`. Bytes injected during a dump → ignored, stream unchanged.
- `uart_txactive` held high for 100 cycles mid-dump → no strobe while high and no byte lost. `reset` mid-dump → all outputs 0 next cycle, IDLE.
